// File: rtl/gmii_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_pkg
// Brief    : Shared types and constants for the GMII transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_GAP        = 3'd4
    } sched_state_t;

    localparam logic [7:0] c_pkt_video = 8'h00;
    localparam logic [7:0] c_pkt_audio = 8'h01;

    localparam int c_aux_bytes_def = 49;
    localparam int c_frame_cnt_w   = 16;
    localparam int c_aud_len_w     = 12;
    localparam int c_timer_w       = 5;
    localparam int c_vid_run_w     = 3;

endpackage
`default_nettype wire

// File: rtl/tx_sched_timer.sv
`default_nettype none
// ============================================================================
// Module   : tx_sched_timer
// Brief    : Loadable down-counter with zero flag; holds at zero.
// Revision : 1.0 - initial release
// ============================================================================
module tx_sched_timer
    import gmii_tx_pkg::*;
#(
    parameter int WIDTH = c_timer_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gmii_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_sched
// Brief    : Video/audio transmit arbiter with start timeout and frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_sched
    import gmii_tx_pkg::*;
#(
    parameter int MAX_VID_RUN   = 4,
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 16,
    parameter int AUX_BYTES     = c_aux_bytes_def
) (
    input  logic                     tx_clk,
    input  logic                     sys_rst_n,
    input  logic                     enable,
    input  logic                     vid_req,
    input  logic                     aud_req,
    input  logic [3:0]               aud_ade_num,
    input  logic                     tx_en,
    input  logic                     err_clr,
    output logic                     vid_go,
    output logic                     aud_go,
    output logic                     sel_audio,
    output logic [c_aud_len_w-1:0]   aud_len,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [c_frame_cnt_w-1:0] vid_cnt,
    output logic [c_frame_cnt_w-1:0] aud_cnt
);

    localparam logic [c_timer_w-1:0]   c_start_load = c_timer_w'(START_TIMEOUT);
    localparam logic [c_timer_w-1:0]   c_ifg_load   = c_timer_w'(IFG_CYCLES);
    localparam logic [c_timer_w-1:0]   c_timer_one  = c_timer_w'(1);
    localparam logic [c_vid_run_w-1:0] c_max_run    = c_vid_run_w'(MAX_VID_RUN);
    localparam logic [c_aud_len_w-1:0] c_aux_bytes  = c_aud_len_w'(AUX_BYTES);

    sched_state_t               r_state;
    sched_state_t               w_next_state;
    logic [7:0]                 r_pkt_type;
    logic [c_aud_len_w-1:0]     r_aud_len;
    logic [c_vid_run_w-1:0]     r_vid_run;
    logic                       r_timeout_err;
    logic [c_frame_cnt_w-1:0]   r_vid_cnt;
    logic [c_frame_cnt_w-1:0]   r_aud_cnt;

    logic                       w_req_any;
    logic                       w_pick_audio;
    logic                       w_grant;
    logic                       w_start_timeout;
    logic                       w_frame_done;
    logic                       w_gap_done;
    logic [c_aud_len_w-1:0]     w_aud_len;
    logic                       w_tmr_load;
    logic [c_timer_w-1:0]       w_tmr_val;
    logic                       w_tmr_dec;
    logic [c_timer_w-1:0]       w_tmr_count;
    logic                       w_tmr_zero;

    assign w_req_any    = enable && (vid_req || aud_req);
    assign w_pick_audio = aud_req && (!vid_req || (r_vid_run >= c_max_run));
    assign w_grant      = (r_state == ST_IDLE) && w_req_any;
    assign w_aud_len    = c_aux_bytes * ({8'd0, aud_ade_num} + 12'd1);

    assign w_start_timeout = (r_state == ST_WAIT_START) && !tx_en && w_tmr_zero;
    assign w_frame_done    = (r_state == ST_ACTIVE) && !tx_en;
    // Leaving GAP as the timer reaches zero makes fall-to-go exactly IFG+2.
    assign w_gap_done      = (r_state == ST_GAP) && (w_tmr_count <= c_timer_one);

    tx_sched_timer #(
        .WIDTH (c_timer_w)
    ) u_timer (
        .clk        (tx_clk),
        .rst_n      (sys_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:       if (w_req_any) w_next_state = ST_GRANT;
            ST_GRANT:      w_next_state = ST_WAIT_START;
            ST_WAIT_START: begin
                if (tx_en)           w_next_state = ST_ACTIVE;
                else if (w_tmr_zero) w_next_state = ST_GAP;
            end
            ST_ACTIVE:     if (!tx_en) w_next_state = ST_GAP;
            ST_GAP:        if (w_gap_done) w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        vid_go     = 1'b0;
        aud_go     = 1'b0;
        busy       = (r_state != ST_IDLE);
        w_tmr_load = 1'b0;
        w_tmr_val  = c_ifg_load;
        w_tmr_dec  = 1'b0;
        case (r_state)
            ST_GRANT: begin
                vid_go     = !sel_audio;
                aud_go     = sel_audio;
                w_tmr_load = 1'b1;
                w_tmr_val  = c_start_load;
            end
            ST_WAIT_START: begin
                w_tmr_load = w_start_timeout;
                w_tmr_dec  = !tx_en;
            end
            ST_ACTIVE: w_tmr_load = !tx_en;
            ST_GAP:    w_tmr_dec  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pkt_type    <= c_pkt_video;
            r_aud_len     <= '0;
            r_vid_run     <= '0;
            r_timeout_err <= 1'b0;
            r_vid_cnt     <= '0;
            r_aud_cnt     <= '0;
        end else begin
            if (w_grant) begin
                if (w_pick_audio) begin
                    r_pkt_type <= c_pkt_audio;
                    r_aud_len  <= w_aud_len;
                    r_vid_run  <= '0;
                end else begin
                    r_pkt_type <= c_pkt_video;
                    if (r_vid_run < c_max_run) r_vid_run <= r_vid_run + 1'b1;
                end
            end
            if (w_start_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
            if (w_frame_done) begin
                if (sel_audio) r_aud_cnt <= r_aud_cnt + 1'b1;
                else           r_vid_cnt <= r_vid_cnt + 1'b1;
            end
        end
    end

    assign sel_audio   = (r_pkt_type == c_pkt_audio);
    assign aud_len     = r_aud_len;
    assign timeout_err = r_timeout_err;
    assign vid_cnt     = r_vid_cnt;
    assign aud_cnt     = r_aud_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmii_tx_sched
// Brief    : Self-checking bench with a timeline-level scheduler model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gmii_tx_sched;

    localparam int MAX_VID_RUN   = 4;
    localparam int IFG_CYCLES    = 12;
    localparam int START_TIMEOUT = 16;
    localparam int AUX_BYTES     = 49;

    logic        tx_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        vid_req = 1'b0;
    logic        aud_req = 1'b0;
    logic [3:0]  aud_ade_num = 4'd0;
    logic        tx_en = 1'b0;
    logic        err_clr = 1'b0;
    logic        vid_go, aud_go, sel_audio, busy, timeout_err;
    logic [11:0] aud_len;
    logic [15:0] vid_cnt, aud_cnt;

    gmii_tx_sched #(
        .MAX_VID_RUN   (MAX_VID_RUN),
        .IFG_CYCLES    (IFG_CYCLES),
        .START_TIMEOUT (START_TIMEOUT),
        .AUX_BYTES     (AUX_BYTES)
    ) dut (
        .tx_clk      (tx_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .vid_req     (vid_req),
        .aud_req     (aud_req),
        .aud_ade_num (aud_ade_num),
        .tx_en       (tx_en),
        .err_clr     (err_clr),
        .vid_go      (vid_go),
        .aud_go      (aud_go),
        .sel_audio   (sel_audio),
        .aud_len     (aud_len),
        .busy        (busy),
        .timeout_err (timeout_err),
        .vid_cnt     (vid_cnt),
        .aud_cnt     (aud_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    // Packetizer stand-in: after a go, wait pk_dmax-bounded cycles, then hold tx_en.
    int pk_dmax = 0, pk_lmin = 4, pk_lmax = 4, pk_mute_pct = 0;
    int pk_wait = 0, pk_rem = 0;
    initial begin
        forever begin
            @(negedge tx_clk);
            if (sys_rst_n && (vid_go || aud_go)) begin
                if ($urandom_range(99, 0) < pk_mute_pct) begin
                    pk_wait = 0;
                    pk_rem  = 0;
                end else begin
                    pk_wait = $urandom_range(pk_dmax, 0);
                    pk_rem  = $urandom_range(pk_lmax, pk_lmin);
                end
            end
            @(posedge tx_clk);
            #1;
            if (!sys_rst_n)      begin pk_wait = 0; pk_rem = 0; tx_en = 1'b0; end
            else if (pk_wait > 0) begin pk_wait--; tx_en = 1'b0; end
            else if (pk_rem > 0)  begin pk_rem--;  tx_en = 1'b1; end
            else                  tx_en = 1'b0;
        end
    end

    // Reference model: one frame at a time described by its go cycle and end
    // cycle; the scheduler may grant again IFG_CYCLES+1 cycles after the end.
    bit          m_frame, m_started, m_sel, m_terr;
    int          m_go_at, m_end, m_run;
    logic [11:0] m_len;
    logic [15:0] m_vc, m_ac;

    int go_cyc[$];
    bit go_aud[$];
    int spacing[$];
    int last_fall = -1, terr_rise = -1;
    bit prev_tx, prev_terr;

    function automatic bit m_idle(input int c);
        return !m_frame || (m_end >= 0 && c >= m_end + IFG_CYCLES + 1);
    endfunction

    initial begin
        bit exp_go, t_set;
        forever begin
            @(negedge tx_clk);
            if (!sys_rst_n) begin
                m_frame = 0; m_started = 0; m_sel = 0; m_terr = 0;
                m_go_at = -1; m_end = -1; m_run = 0;
                m_len = '0; m_vc = '0; m_ac = '0;
                prev_tx = 0; prev_terr = 0; last_fall = -1;
            end else begin
                exp_go = m_frame && (cyc == m_go_at);
                chk("vid_go",      32'(vid_go),      32'(exp_go && !m_sel));
                chk("aud_go",      32'(aud_go),      32'(exp_go && m_sel));
                chk("busy",        32'(busy),        32'(!m_idle(cyc)));
                chk("sel_audio",   32'(sel_audio),   32'(m_sel));
                chk("aud_len",     32'(aud_len),     32'(m_len));
                chk("timeout_err", 32'(timeout_err), 32'(m_terr));
                chk("vid_cnt",     32'(vid_cnt),     32'(m_vc));
                chk("aud_cnt",     32'(aud_cnt),     32'(m_ac));

                if (vid_go || aud_go) begin
                    go_cyc.push_back(cyc);
                    go_aud.push_back(aud_go);
                    if (last_fall >= 0) spacing.push_back(cyc - last_fall);
                end
                if (!tx_en && prev_tx) last_fall = cyc;
                if (timeout_err && !prev_terr) terr_rise = cyc;
                prev_tx   = tx_en;
                prev_terr = timeout_err;

                t_set = 0;
                if (m_frame && m_end < 0 && cyc > m_go_at) begin
                    if (!m_started) begin
                        if (tx_en) m_started = 1;
                        else if (cyc - m_go_at == START_TIMEOUT + 1) begin
                            m_end = cyc;
                            t_set = 1;
                        end
                    end else if (!tx_en) begin
                        m_end = cyc;
                        if (m_sel) m_ac++;
                        else       m_vc++;
                    end
                end
                if (t_set)        m_terr = 1;
                else if (err_clr) m_terr = 0;

                if (m_idle(cyc) && enable && (vid_req || aud_req)) begin
                    m_frame = 1; m_started = 0; m_go_at = cyc + 1; m_end = -1;
                    m_sel = aud_req && (!vid_req || m_run >= MAX_VID_RUN);
                    if (m_sel) begin
                        m_len = 12'(AUX_BYTES * (int'(aud_ade_num) + 1));
                        m_run = 0;
                    end else if (m_run < MAX_VID_RUN) begin
                        m_run++;
                    end
                end
            end
        end
    end

    task automatic wait_go(input int n, input int budget, input string what);
        int k = 0;
        while (go_cyc.size() < n && k < budget) begin tick(1); k++; end
        chk(what, 32'(go_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string what);
        int k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        chk(what, 32'(busy), 32'd0);
    endtask

    task automatic wait_tx(input int budget, input string what);
        int k = 0;
        while (!tx_en && k < budget) begin tick(1); k++; end
        chk(what, 32'(tx_en), 32'd1);
    endtask

    task automatic do_reset(input string what);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk({what, "_vid_go"},  32'(vid_go),      32'd0);
        chk({what, "_aud_go"},  32'(aud_go),      32'd0);
        chk({what, "_sel"},     32'(sel_audio),   32'd0);
        chk({what, "_len"},     32'(aud_len),     32'd0);
        chk({what, "_busy"},    32'(busy),        32'd0);
        chk({what, "_terr"},    32'(timeout_err), 32'd0);
        chk({what, "_vcnt"},    32'(vid_cnt),     32'd0);
        chk({what, "_acnt"},    32'(aud_cnt),     32'd0);
        tick(2);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int n0, g, c0;
        tick(1);
        do_reset("reset");

        // Video only, long frames: fall-to-go spacing and frame count.
        pk_dmax = 0; pk_lmin = 1300; pk_lmax = 1300;
        enable = 1; vid_req = 1;
        for (int k = 0; k < 5000 && vid_cnt < 3; k++) tick(1);
        chk("video_frames", 32'(vid_cnt), 32'd3);
        enable = 0; vid_req = 0;
        wait_idle(100, "video_idle");
        chk("video_spacing_n", 32'(spacing.size()), 32'd2);
        for (int i = 0; i < spacing.size(); i++)
            chk("video_spacing", 32'(spacing[i]), 32'(IFG_CYCLES + 2));

        // Audio length latch.
        pk_lmin = 5; pk_lmax = 20; pk_dmax = 3;
        aud_ade_num = 4'd3; aud_req = 1; enable = 1;
        n0 = go_cyc.size();
        wait_go(n0 + 1, 50, "aud3_go");
        enable = 0; aud_req = 0;
        chk("aud3_type", 32'(go_aud[$]), 32'd1);
        chk("aud3_sel",  32'(sel_audio), 32'd1);
        chk("aud3_len",  32'(aud_len),   32'd196);
        wait_idle(100, "aud3_idle");
        aud_ade_num = 4'd15; aud_req = 1; enable = 1;
        wait_go(n0 + 2, 50, "aud15_go");
        enable = 0; aud_req = 0;
        chk("aud15_len", 32'(aud_len), 32'd784);
        wait_idle(100, "aud15_idle");

        // Start timeout: tx_en never rises.
        pk_mute_pct = 100;
        c0 = vid_cnt + aud_cnt;
        enable = 1; vid_req = 1;
        wait_go(go_cyc.size() + 1, 50, "to1_go");
        enable = 0; vid_req = 0;
        g = go_cyc[$];
        wait_idle(100, "to1_idle");
        // 17 WAIT_START cycles follow the go cycle; the flag shows on the next one.
        chk("to1_latency", 32'(terr_rise - g), 32'(START_TIMEOUT + 2));
        chk("to1_flag",    32'(timeout_err),   32'd1);
        chk("to1_counts",  32'(vid_cnt + aud_cnt), 32'(c0));
        err_clr = 1; tick(1); err_clr = 0; tick(1);
        chk("to_clear", 32'(timeout_err), 32'd0);
        enable = 1; vid_req = 1;
        wait_go(go_cyc.size() + 1, 50, "to2_go");
        enable = 0; vid_req = 0;
        g = go_cyc[$];
        while (cyc < g + START_TIMEOUT + 1) tick(1);
        chk("to2_before", 32'(timeout_err), 32'd0);
        err_clr = 1; tick(1); err_clr = 0;
        chk("to2_set_wins", 32'(timeout_err), 32'd1);
        wait_idle(100, "to2_idle");
        pk_mute_pct = 0;

        // Enable dropped mid-frame.
        pk_dmax = 0; pk_lmin = 50; pk_lmax = 50;
        enable = 1; vid_req = 1; aud_req = 1;
        wait_go(go_cyc.size() + 1, 50, "dis_go");
        wait_tx(20, "dis_tx");
        tick(2);
        enable = 0;
        c0 = vid_cnt + aud_cnt;
        n0 = go_cyc.size();
        wait_idle(200, "dis_idle");
        tick(40);
        chk("dis_counted",  32'(vid_cnt + aud_cnt), 32'(c0 + 1));
        chk("dis_no_grant", 32'(go_cyc.size()),     32'(n0));
        aud_req = 0;

        // Async reset mid-frame, then grant two cycles after release.
        pk_lmin = 200; pk_lmax = 200;
        enable = 1; vid_req = 1;
        wait_go(go_cyc.size() + 1, 50, "ar_go");
        wait_tx(20, "ar_tx");
        tick(3);
        chk("ar_busy", 32'(busy), 32'd1);
        do_reset("ar");
        tick(1);
        chk("ar_regrant", 32'(vid_go), 32'd1);
        enable = 0; vid_req = 0;
        wait_idle(400, "ar_idle");
        tick(1);
        do_reset("rst2");

        // Starvation bound with both requests held.
        pk_dmax = 3; pk_lmin = 4; pk_lmax = 30;
        n0 = go_cyc.size();
        aud_ade_num = 4'd1; enable = 1; vid_req = 1; aud_req = 1;
        wait_go(n0 + 10, 2000, "starve_go");
        enable = 0;
        wait_idle(200, "starve_idle");
        vid_req = 0; aud_req = 0;
        for (int i = 0; i < 10 && n0 + i < go_cyc.size(); i++)
            chk("starve_order", 32'(go_aud[n0 + i]), 32'((i % 5) == 4));
        chk("starve_aud_cnt", 32'(aud_cnt), 32'd2);
        chk("starve_vid_cnt", 32'(vid_cnt), 32'd8);

        // Randomized traffic, including late starts and occasional timeouts.
        pk_dmax = 18; pk_lmin = 1; pk_lmax = 40; pk_mute_pct = 10;
        for (int i = 0; i < 6000; i++) begin
            enable      = ($urandom_range(9, 0) != 0);
            vid_req     = $urandom_range(1, 0) != 0;
            aud_req     = $urandom_range(1, 0) != 0;
            aud_ade_num = 4'($urandom_range(15, 0));
            err_clr     = ($urandom_range(19, 0) == 0);
            if (i == 3000) do_reset("rand_rst");
            else           tick(1);
        end
        enable = 0; vid_req = 0; aud_req = 0; err_clr = 0;
        wait_idle(200, "rand_idle");
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
